mem_rd_arbiter: RTL

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_rd_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory read arbiter: FSM states, grant
// encoding and the AXI-style OKAY response code.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_DCACHE = 1'b1
  } arb_gnt_e;

  localparam logic [2:0] RRESP_OKAY = 3'b000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. req[0]/sel=0 is requester 0, req[1]/sel=1 is
// requester 1. A lone requester wins; otherwise (both or none) the side that
// was not served last is selected, so the idle choice is already fair.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  // Select the lone requester, else alternate away from the last winner
  always_comb begin
    sel = ~last;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~last;
    endcase
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one memory read port between the icache and dcache with a single
// transaction in flight. The address is registered on the requester
// handshake, issued on the memory address channel, and the data channel is
// routed only to the granted requester while the FSM sits in ARB_DATA.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned ICACHE_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icache_arvalid,
  output logic                icache_arready,
  input  logic [DATA_LEN-1:0] icache_raddr,
  output logic                icache_rvalid,
  input  logic                icache_rready,
  output logic [2:0]          icache_rresp,
  output logic [DATA_LEN-1:0] icache_rdata,
  input  logic                dcache_arvalid,
  output logic                dcache_arready,
  input  logic [DATA_LEN-1:0] dcache_raddr,
  output logic                dcache_rvalid,
  input  logic                dcache_rready,
  output logic [2:0]          dcache_rresp,
  output logic [DATA_LEN-1:0] dcache_rdata,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [DATA_LEN-1:0] mem_raddr,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [2:0]          mem_rresp,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  arb_state_e          state_q, state_d;
  arb_gnt_e            grant_q, grant_d;
  arb_gnt_e            last_q, last_d;
  logic                mem_arvalid_q, mem_arvalid_d;
  logic [DATA_LEN-1:0] mem_raddr_q, mem_raddr_d;
  logic                pick_sel;
  logic                req_hs;

  rr_pick2 u_pick (
    .req  ({dcache_arvalid, icache_arvalid}),
    .last (last_q),
    .sel  (pick_sel)
  );

  assign mem_arvalid = mem_arvalid_q;
  assign mem_raddr   = mem_raddr_q;

  // Next-state logic: accept a request, issue the address, wait for data
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    mem_arvalid_d = mem_arvalid_q;
    mem_raddr_d   = mem_raddr_q;
    req_hs        = pick_sel ? dcache_arvalid : icache_arvalid;
    case (state_q)
      ARB_IDLE: begin
        mem_arvalid_d = 1'b0;
        if (req_hs) begin
          state_d       = ARB_ADDR;
          grant_d       = arb_gnt_e'(pick_sel);
          mem_raddr_d   = pick_sel ? dcache_raddr : icache_raddr;
          mem_arvalid_d = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        if (mem_arvalid_q && mem_arready) begin
          mem_arvalid_d = 1'b0;
          state_d       = ARB_DATA;
        end else begin
          state_d = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        mem_arvalid_d = 1'b0;
        if (mem_rvalid && mem_rready) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_DATA;
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        mem_arvalid_d = 1'b0;
      end
    endcase
  end

  // Output routing: arready only in IDLE, data channel only in DATA
  always_comb begin
    icache_arready = 1'b0;
    dcache_arready = 1'b0;
    mem_rready     = 1'b0;
    icache_rvalid  = 1'b0;
    dcache_rvalid  = 1'b0;
    icache_rresp   = RRESP_OKAY;
    dcache_rresp   = RRESP_OKAY;
    icache_rdata   = {DATA_LEN{1'b0}};
    dcache_rdata   = {DATA_LEN{1'b0}};
    case (state_q)
      ARB_IDLE: begin
        icache_arready = ~pick_sel;
        dcache_arready = pick_sel;
      end
      ARB_DATA: begin
        if (grant_q == GNT_DCACHE) begin
          mem_rready    = dcache_rready;
          dcache_rvalid = mem_rvalid;
          dcache_rresp  = mem_rresp;
          dcache_rdata  = mem_rdata;
        end else begin
          mem_rready    = icache_rready;
          icache_rvalid = mem_rvalid;
          icache_rresp  = mem_rresp;
          icache_rdata  = mem_rdata;
        end
      end
      default: begin
        mem_rready = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= GNT_ICACHE;
      mem_arvalid_q <= 1'b0;
      mem_raddr_q   <= {DATA_LEN{1'b0}};
      if (ICACHE_FIRST != 32'd0) begin
        last_q <= GNT_DCACHE;
      end else begin
        last_q <= GNT_ICACHE;
      end
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      mem_arvalid_q <= mem_arvalid_d;
      mem_raddr_q   <= mem_raddr_d;
    end
  end

endmodule
